// File: rtl/moonbase_mem_pkg.sv
// Shared definitions for the moonbase SRAM pin bus: sequencer states, pin bit
// positions and the helpers that build the byte driven on mem_out.
package moonbase_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_H,
        ST_RD_L,
        ST_WR_SKIP,
        ST_WR_L,
        ST_WR_H
    } state_t;

    localparam int STB_BIT  = 7;
    localparam int WE_N_BIT = 5;
    localparam int DS_N_BIT = 4;

    localparam logic [7:0] MEM_IDLE_DATA = 8'h30;
    localparam logic [7:0] MEM_RST       = 8'h80;

    // Address strobe byte; also realigns the external nibble phase to "high".
    function automatic logic [7:0] mem_strobe(input logic [6:0] addr);
        logic [7:0] b;
        b          = {1'b0, addr};
        b[STB_BIT] = 1'b1;
        return b;
    endfunction

    // Write-data phase byte: we_n and ds_n both low, nibble on the low bits.
    function automatic logic [7:0] mem_wr_nib(input logic [3:0] nib);
        logic [7:0] b;
        b           = MEM_IDLE_DATA;
        b[WE_N_BIT] = 1'b0;
        b[DS_N_BIT] = 1'b0;
        b[3:0]      = nib;
        return b;
    endfunction

endpackage

// File: rtl/moonbase_rr_arb2.sv
// Two-way arbiter: round-robin (or r0-priority) over unmasked requests, with the
// last winner remembered only when the grant is actually taken.
module moonbase_rr_arb2
    import moonbase_mem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       valid,
    output logic       grant
);

    logic       last_grant;
    logic [1:0] elig;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        elig  = req & ~mask;
        valid = |elig;
        grant = 1'b0;
        if (elig == 2'b11) begin
            grant = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            grant = elig[1];
        end
    end

    // Reset value 1 lets r0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (take && valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/moonbase_sram_arbiter.sv
// Arbitrates two word requesters onto the nibble-multiplexed SRAM pin bus and
// sequences strobe, read-nibble and write-nibble phases with registered outputs.
module moonbase_sram_arbiter
    import moonbase_mem_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [7:0]        r0_wdata,
    output logic              r0_ack,
    output logic [7:0]        r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [7:0]        r1_wdata,
    output logic              r1_ack,
    output logic [7:0]        r1_rdata,
    output logic [7:0]        mem_out,
    input  logic [3:0]        mem_nib_in,
    output logic              busy,
    output logic              grant_id
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [3:0]        rd_hi_q;

    logic              arb_valid;
    logic              arb_grant;
    logic [ADDR_W-1:0] sel_addr;

    assign sel_addr = arb_grant ? r1_addr : r0_addr;

    // A requester in its own ack cycle is masked: its held req means a new transaction.
    moonbase_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({r1_req, r0_req}),
        .mask ({r1_ack, r0_ack}),
        .take (state == ST_IDLE),
        .valid(arb_valid),
        .grant(arb_grant)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mem_out  <= MEM_RST;
            busy     <= 1'b0;
            r0_ack   <= 1'b0;
            r1_ack   <= 1'b0;
            r0_rdata <= 8'h00;
            r1_rdata <= 8'h00;
            grant_id <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
            rd_hi_q  <= 4'h0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id <= arb_grant;
                        addr_q   <= sel_addr;
                        we_q     <= arb_grant ? r1_we : r0_we;
                        wdata_q  <= arb_grant ? r1_wdata : r0_wdata;
                        mem_out  <= mem_strobe(7'(sel_addr));
                        busy     <= 1'b1;
                        state    <= ST_ADDR;
                    end else begin
                        mem_out <= mem_strobe(7'(addr_q));
                    end
                end
                ST_ADDR: begin
                    mem_out <= MEM_IDLE_DATA;
                    state   <= we_q ? ST_WR_SKIP : ST_RD_H;
                end
                ST_RD_H: begin
                    rd_hi_q <= mem_nib_in;
                    mem_out <= MEM_IDLE_DATA;
                    state   <= ST_RD_L;
                end
                ST_RD_L: begin
                    if (grant_id) begin
                        r1_ack   <= 1'b1;
                        r1_rdata <= {rd_hi_q, mem_nib_in};
                    end else begin
                        r0_ack   <= 1'b1;
                        r0_rdata <= {rd_hi_q, mem_nib_in};
                    end
                    mem_out <= mem_strobe(7'(addr_q));
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                // High phase with we_n high: burns the phase without committing.
                ST_WR_SKIP: begin
                    mem_out <= mem_wr_nib(wdata_q[3:0]);
                    state   <= ST_WR_L;
                end
                ST_WR_L: begin
                    mem_out <= mem_wr_nib(wdata_q[7:4]);
                    state   <= ST_WR_H;
                end
                ST_WR_H: begin
                    if (grant_id) begin
                        r1_ack <= 1'b1;
                    end else begin
                        r0_ack <= 1'b1;
                    end
                    mem_out <= mem_strobe(7'(addr_q));
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    mem_out <= mem_strobe(7'(addr_q));
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moonbase_sram_arbiter.sv
// Directed bench for moonbase_sram_arbiter with a behavioural nibble-bus SRAM
// model; all expected values are hand-derived constants or the model contents.
module tb_moonbase_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [6:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_ack, r1_ack;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] mem_out;
    logic [3:0] mem_nib_in;
    logic       busy, grant_id;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    moonbase_sram_arbiter #(
        .ADDR_W    (7),
        .FIXED_PRIO(1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .mem_out   (mem_out),
        .mem_nib_in(mem_nib_in),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    function automatic logic [7:0] init_val(input int a);
        if (a == 5) return 8'hf1;
        return 8'(a * 7 + 19);
    endfunction

    // External SRAM: strobe latches address and realigns phase; phase toggles otherwise.
    logic [7:0] sram [0:127];
    logic [6:0] m_addr     = 7'h00;
    logic       m_phase_hi = 1'b1;
    logic [3:0] m_lo       = 4'h0;
    bit         loaded     = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 128; i++) sram[i] <= init_val(i);
            loaded <= 1'b1;
        end
        if (mem_out[7]) begin
            m_addr     <= mem_out[6:0];
            m_phase_hi <= 1'b1;
        end else begin
            if (!mem_out[5] && !mem_out[4]) begin
                if (m_phase_hi) sram[m_addr] <= {mem_out[3:0], m_lo};
                else            m_lo         <= mem_out[3:0];
            end
            m_phase_hi <= ~m_phase_hi;
        end
    end

    assign mem_nib_in = m_phase_hi ? sram[m_addr][7:4] : sram[m_addr][3:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_any_ack(input int budget, output int who, output int cycles);
        who    = -1;
        cycles = -1;
        for (int c = 1; c <= budget && who < 0; c++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) begin
                who    = r1_ack ? 1 : 0;
                cycles = c;
            end
        end
    endtask

    int         who, cyc;
    logic       acks_seen;
    logic [7:0] wr_seq [4];

    initial begin
        rst = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 7'h00; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 7'h00; r1_wdata = 8'h00;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_mem_out", mem_out, 8'h80);
        check("rst_busy", busy, 0);
        check("rst_r0_ack", r0_ack, 0);
        check("rst_r1_ack", r1_ack, 0);
        check("rst_r0_rdata", r0_rdata, 0);
        check("rst_r1_rdata", r1_rdata, 0);
        check("rst_grant_id", grant_id, 0);
        @(negedge clk);
        check("idle_mem_out", mem_out, 8'h80);

        // r0 read of 0x05
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 7'h05;
        @(negedge clk);
        check("rd_addr_mem_out", mem_out, 8'h85);
        check("rd_busy", busy, 1);
        check("rd_grant_id", grant_id, 0);
        @(negedge clk);
        check("rd_h_mem_out", mem_out, 8'h30);
        @(negedge clk);
        check("rd_l_mem_out", mem_out, 8'h30);
        check("rd_no_early_ack", r0_ack, 0);
        @(negedge clk);
        check("rd_r0_ack", r0_ack, 1);
        check("rd_r0_rdata", r0_rdata, 8'hf1);
        check("rd_r1_ack", r1_ack, 0);
        check("rd_ack_busy", busy, 0);
        r0_req = 1'b0;
        @(negedge clk);
        check("rd_ack_pulse", r0_ack, 0);

        // r1 write of 0x3c to 0x7a
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 7'h7a; r1_wdata = 8'h3c;
        wr_seq[0] = 8'hfa; wr_seq[1] = 8'h30; wr_seq[2] = 8'h0c; wr_seq[3] = 8'h03;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wr_mem_out_%0d", i), mem_out, wr_seq[i]);
            check($sformatf("wr_no_ack_%0d", i), r1_ack, 0);
        end
        @(negedge clk);
        check("wr_r1_ack", r1_ack, 1);
        check("wr_r0_ack", r0_ack, 0);
        check("wr_grant_id", grant_id, 1);
        check("wr_r0_rdata_hold", r0_rdata, 8'hf1);
        check("wr_sram_7a", sram[7'h7a], 8'h3c);
        check("wr_sram_79", sram[7'h79], init_val(8'h79));
        check("wr_sram_7b", sram[7'h7b], init_val(8'h7b));
        r1_req = 1'b0;

        // Simultaneous requests right after reset: r0 wins, r1 follows
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 7'h10;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 7'h11; r1_wdata = 8'ha7;
        @(negedge clk);
        check("tie_first_grant", grant_id, 0);
        check("tie_first_addr", mem_out, 8'h90);
        repeat (3) @(negedge clk);
        check("tie_r0_ack", r0_ack, 1);
        check("tie_r0_rdata", r0_rdata, init_val(8'h10));
        r0_req = 1'b0;
        @(negedge clk);
        check("tie_second_grant", grant_id, 1);
        check("tie_second_addr", mem_out, 8'h91);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("tie_r1_ack", r1_ack, 1);
        check("tie_sram_11", sram[7'h11], 8'ha7);
        r1_req = 1'b0;

        // Both held for six transactions: strict alternation, four cycles apart
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 7'h05;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 7'h33;
        for (int k = 0; k < 6; k++) begin
            wait_any_ack(10, who, cyc);
            check($sformatf("rr_who_%0d", k), who, k % 2);
            check($sformatf("rr_gap_%0d", k), cyc, 4);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        check("rr_r0_rdata", r0_rdata, 8'hf1);
        check("rr_r1_rdata", r1_rdata, init_val(8'h33));

        // r0 write of 0x55 to 0x20 abandoned by reset in WR_L
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 7'h20; r0_wdata = 8'h55;
        @(negedge clk);
        check("abort_addr", mem_out, 8'ha0);
        @(negedge clk);
        check("abort_skip", mem_out, 8'h30);
        @(negedge clk);
        check("abort_wr_l", mem_out, 8'h05);
        rst = 1'b0; r0_req = 1'b0;
        @(negedge clk);
        check("abort_mem_out", mem_out, 8'h80);
        check("abort_busy", busy, 0);
        check("abort_grant_id", grant_id, 0);
        rst = 1'b1;
        acks_seen = r0_ack | r1_ack;
        repeat (6) begin
            @(negedge clk);
            acks_seen = acks_seen | r0_ack | r1_ack;
        end
        check("abort_no_ack", acks_seen, 0);
        check("abort_sram_20", sram[7'h20], init_val(8'h20));
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 7'h20;
        wait_any_ack(8, who, cyc);
        r1_req = 1'b0;
        check("post_abort_who", who, 1);
        check("post_abort_lat", cyc, 4);
        check("post_abort_rdata", r1_rdata, init_val(8'h20));

        // req dropped right after grant: transaction still completes with ack
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 7'h7a;
        @(negedge clk);
        r0_req = 1'b0;
        wait_any_ack(6, who, cyc);
        check("drop_who", who, 0);
        check("drop_lat", cyc, 3);
        check("drop_rdata", r0_rdata, 8'h3c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/moonbase_sram_arbiter.md
Name: moonbase_sram_arbiter

Overview:
- Controller and arbiter for the 7-bit-address external SRAM behind the moonbase 8-bit CPU's nibble-multiplexed pin bus.
- Two word-level requesters share the bus:
  - r0: CPU fetch/data port.
  - r1: loader/debug port.
- The block picks the winner round-robin and sequences the pin protocol: address strobe, high/low nibble read phases, and low-then-high nibble write phases with a write commit.
- It sits between the core's memory port and io_out/io_in, replacing ad-hoc pin sequencing inside the core.

Parameters:
- ADDR_W, 7, SRAM word address width; must be ≤7 because the address is carried on mem_out[6:0].
- FIXED_PRIO, 0, 0 = round-robin; 1 = r0 always wins ties.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- r0_req  in  1  request; held high until r0_ack
- r0_we  in  1  1 = write, 0 = read; stable while r0_req is high
- r0_addr  in  ADDR_W  word address; stable while r0_req is high
- r0_wdata  in  8  write data; stable while r0_req is high
- r0_ack  out  1  one-cycle completion pulse
- r0_rdata  out  8  read data, valid in the r0_ack cycle
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as r0
- mem_out  out  8  pin byte, encoded per state (see Behaviour)
- mem_nib_in  in  4  SRAM nibble returned by the external bus
- busy  out  1  high in every state except IDLE
- grant_id  out  1  id of the requester currently owning the bus; last owner when idle

Behaviour:
- mem_out encoding:
  - bit7 = address strobe. When set, bits[6:0] carry the address and the external nibble phase resets to "high".
  - When bit7 = 0: bit6 = 0, bit5 = we_n, bit4 = ds_n (low only in write-data phases), bits[3:0] = write nibble (0 on reads).
  - The external phase toggles every cycle while strobe = 0: the first cycle after strobe is the high phase, the second the low phase, and so on.
- States: IDLE, ADDR, RD_H, RD_L, WR_SKIP, WR_L, WR_H.
- IDLE:
  - mem_out = {1, held_addr}, keeping the bus phase-aligned.
  - Arbitrate on the requests sampled this cycle; with any request pending, latch the winner's addr/we/wdata, update grant_id, and go to ADDR.
  - With no request, stay in IDLE.
- ADDR: mem_out = {1, addr}. Next state is RD_H if we = 0, otherwise WR_SKIP.
- RD_H: mem_out = 8'h30. Capture mem_nib_in into rdata[7:4] at the closing edge. Next state RD_L.
- RD_L: mem_out = 8'h30. Capture mem_nib_in into rdata[3:0]. Next state IDLE, with ack pulsed in that IDLE cycle.
- WR_SKIP: mem_out = 8'h30 (high phase with we_n = 1, so no commit). Next state WR_L.
- WR_L: mem_out = {0,0,0,0,wdata[3:0]}. The external side latches the low nibble. Next state WR_H.
- WR_H: mem_out = {0,0,0,0,wdata[7:4]}. The external side commits the full byte. Next state IDLE, with ack pulsed.
- Latency, with request sampled in IDLE cycle t:
  - read: ack at t+4, rdata valid in the same cycle;
  - write: ack at t+5.
- ack and rdata are registered. rdata of the non-acked port holds its previous value.
- Ack-cycle masking: the acked requester is masked from arbitration in its ack cycle. If it keeps req high, that is a new transaction, eligible from t_ack+1.
- Round-robin: with both requests present, grant the one not granted last. last_grant resets to 1, so r0 wins the first tie. With FIXED_PRIO = 1, r0 wins every tie.
- A single requester is granted immediately regardless of last_grant.
- No starvation: with both requesters continuously requesting, grants strictly alternate.
- Reset (rst = 0 at a clock edge):
  - state = IDLE, mem_out = 8'h80, acks = 0, rdata = 0, grant_id = 0, last_grant = 1, busy = 0.
  - In-flight transactions are abandoned with no ack.
  - A write reset in WR_SKIP or WR_L does not modify SRAM.
  - A write reset after WR_H was driven has already committed.
- req deasserted mid-transaction (protocol violation): the transaction completes and the ack is still pulsed.

Decomposition:
- Package moonbase_mem_pkg holds:
  - state enum;
  - pin bit positions: STB_BIT = 7, WE_N_BIT = 5, DS_N_BIT = 4;
  - constants: MEM_IDLE_DATA = 8'h30, MEM_RST = 8'h80.
- Sub-module moonbase_rr_arb2: 2-way round-robin arbiter with mask input, last_grant register, FIXED_PRIO parameter.
- Sequencing FSM and pin encoding stay in the top module.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release → mem_out = 8'h80, busy = 0, both acks 0, both rdata 0.
- r0 read of addr 0x05 (SRAM model holds 0xf1) → mem_out 0x85 in ADDR, then 0x30 twice; r0_ack at t+4 with r0_rdata = 0xf1; r1_ack stays 0.
- r1 write of 0x3c to addr 0x7a → mem_out sequence 0xfa, 0x30, 0x0c, 0x03; r1_ack at t+5; model SRAM[0x7a] = 0x3c; no other locations change.
- r0 read (addr 0x10) and r1 write (addr 0x11) raised in the same cycle after reset → r0 granted first, r1 starts in r0's ack cycle +1; grant_id sequence 0 then 1.
- Both requests held high for 6 transactions → grants alternate 0,1,0,1,0,1; no requester waits more than one transaction.
- r0 write of 0x55 to addr 0x20, with rst pulsed low during WR_L → SRAM[0x20] unchanged; no ack; mem_out = 8'h80 the cycle after reset; the next request completes normally.
